// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter with a registered one-hot grant.
// Each winner holds the grant for its beat quota; handover happens without an idle cycle.
module weighted_rr_arbiter #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(PORTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [PORTS-1:0]          i_req_vec,
  input  logic [PORTS*WEIGHT_W-1:0] i_weight,
  input  logic                      i_mode,
  input  logic                      i_beat,
  output logic [PORTS-1:0]          o_grant_vec,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic                      o_grant_valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [WEIGHT_W-1:0] r_credit;

  logic                w_release;
  logic                w_arb;
  logic [IDX_W-1:0]    w_start;
  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [WEIGHT_W-1:0] w_win_weight;
  logic [WEIGHT_W-1:0] w_new_credit;

  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(PORTS)) sum = sum - 32'(PORTS);
    return IDX_W'(sum);
  endfunction

  always_comb begin
    w_release = (r_state == ST_GRANT) &&
                (!i_req_vec[o_grant_idx] || (i_beat && (r_credit == WEIGHT_W'(1))));
    w_arb     = (r_state == ST_IDLE) || w_release;
    // The pointer update on release is forwarded into this cycle's search start.
    w_start   = w_release ? f_wrap(o_grant_idx, 1) : r_ptr;
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (i_mode) begin
        if (!w_found && i_req_vec[i]) begin
          w_found = 1'b1;
          w_win   = IDX_W'(i);
        end
      end else begin
        if (!w_found && i_req_vec[f_wrap(w_start, i)]) begin
          w_found = 1'b1;
          w_win   = f_wrap(w_start, i);
        end
      end
    end
  end

  always_comb begin
    w_win_weight = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (IDX_W'(i) == w_win) w_win_weight = i_weight[i*WEIGHT_W +: WEIGHT_W];
    end
    w_new_credit = (w_win_weight == '0) ? WEIGHT_W'(1) : w_win_weight;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_credit      <= '0;
      o_grant_vec   <= '0;
      o_grant_idx   <= '0;
      o_grant_valid <= 1'b0;
    end else begin
      if (w_release) r_ptr <= w_start;
      if (w_arb) begin
        if (w_found) begin
          r_state       <= ST_GRANT;
          r_credit      <= w_new_credit;
          o_grant_vec   <= {{(PORTS-1){1'b0}}, 1'b1} << w_win;
          o_grant_idx   <= w_win;
          o_grant_valid <= 1'b1;
        end else begin
          r_state       <= ST_IDLE;
          r_credit      <= '0;
          o_grant_vec   <= '0;
          o_grant_idx   <= '0;
          o_grant_valid <= 1'b0;
        end
      end else if (r_state == ST_GRANT && i_beat) begin
        r_credit <= r_credit - WEIGHT_W'(1);
      end
    end
  end

endmodule
